// File: rtl/fdiv_sched.sv
// fdiv_sched: round-robin scheduler sharing one combinational fdiv among
// N_REQ requesters. Operands of the granted requester are registered onto
// the divider inputs, held for DIV_CYCLES cycles, then quotient and flags are
// captured and returned with the requester index.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        packed operands, slot i at [i*WIDTH +: WIDTH]
//   req_round           per-requester rounding mode (1 = RNE, 0 = truncate)
//   div_a, div_b        registered operands to fdiv
//   div_round_mode      registered rounding mode to fdiv
//   div_r, div_flags    fdiv result and {invalid,divzero,overflow,underflow,inexact}
//   rsp_valid/rsp_ready response handshake
//   rsp_id, rsp_r       owning requester index, captured quotient
//   rsp_flags           captured flags
//   sticky_flags        OR of captured flags since reset / last clear
//   flags_clr           synchronous clear of sticky_flags (capture wins)
//   busy                high whenever not IDLE
//   ops_done            completed response handshakes, wraps at 16 bits
module fdiv_sched #(
  parameter int EXP        = 8,
  parameter int FRAC       = 23,
  parameter int WIDTH      = EXP + FRAC + 1,
  parameter int N_REQ      = 4,
  parameter int DIV_CYCLES = 2,
  parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_round,
  output logic [WIDTH-1:0]       div_a,
  output logic [WIDTH-1:0]       div_b,
  output logic                   div_round_mode,
  input  logic [WIDTH-1:0]       div_r,
  input  logic [4:0]             div_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_r,
  output logic [4:0]             rsp_flags,
  output logic [4:0]             sticky_flags,
  input  logic                   flags_clr,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic [WIDTH-1:0]  gnt_a, gnt_b;
  logic              gnt_round;
  logic              accept, capture, rsp_hs;
  int unsigned       idx;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last) + k) % 32'(N_REQ);
      if (!gnt_found && |(req_valid & (N_REQ'(1) << idx))) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  // Operand mux for the granted slot.
  always_comb begin
    gnt_a     = '0;
    gnt_b     = '0;
    gnt_round = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        gnt_a     = req_a[i*WIDTH +: WIDTH];
        gnt_b     = req_b[i*WIDTH +: WIDTH];
        gnt_round = req_round[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_hs     = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          accept     = 1'b1;
          req_ready  = N_REQ'(1) << gnt_idx;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_hs     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      last           <= ID_W'(N_REQ - 1);
      div_a          <= '0;
      div_b          <= '0;
      div_round_mode <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_r          <= '0;
      rsp_flags      <= '0;
      sticky_flags   <= '0;
      ops_done       <= '0;
    end else begin
      if (accept) begin
        div_a          <= gnt_a;
        div_b          <= gnt_b;
        div_round_mode <= gnt_round;
        rsp_id         <= gnt_idx;
        last           <= gnt_idx;
        cnt            <= CNT_W'(DIV_CYCLES - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (capture) begin
        rsp_r        <= div_r;
        rsp_flags    <= div_flags;
        rsp_valid    <= 1'b1;
        // A clear on the capture edge drops older flags but keeps this op's.
        sticky_flags <= (flags_clr ? 5'b0 : sticky_flags) | div_flags;
      end else if (flags_clr) begin
        sticky_flags <= '0;
      end

      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + 16'd1;
      end
    end
  end

endmodule
